// File: rtl/bcd2bin.sv
// bcd2bin: sequential 4-digit BCD to 14-bit binary converter using reverse double-dabble
module bcd2bin (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  bcd3,
    input  logic [3:0]  bcd2,
    input  logic [3:0]  bcd1,
    input  logic [3:0]  bcd0,
    output logic        ready,
    output logic        done_tick,
    output logic        err,
    output logic [13:0] bin
);
    typedef enum logic [1:0] {IDLE, OP, DONE} state_t;
    state_t state, state_next;
    logic [3:0] d3, d2, d1, d0, n;
    logic [13:0] bin_reg;
    logic [29:0] sh;
    logic bad;

    function automatic logic [3:0] fix(input logic [3:0] v);
        return (v > 4'd7) ? v - 4'd3 : v;
    endfunction

    // whole digit/result vector moved one place right, zero into the top
    assign sh  = {1'b0, d3, d2, d1, d0, bin_reg[13:1]};
    assign bad = (bcd3 > 4'd9) | (bcd2 > 4'd9) | (bcd1 > 4'd9) | (bcd0 > 4'd9);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? (bad ? DONE : OP) : IDLE;
            OP:      state_next = (n == 4'd1) ? DONE : OP;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            d3      <= '0;
            d2      <= '0;
            d1      <= '0;
            d0      <= '0;
            n       <= '0;
            bin_reg <= '0;
            err     <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                d3      <= bcd3;
                d2      <= bcd2;
                d1      <= bcd1;
                d0      <= bcd0;
                bin_reg <= '0;
                err     <= bad;
                if (!bad) n <= 4'd14;
            end else if (state == OP) begin
                d3      <= fix(sh[29:26]);
                d2      <= fix(sh[25:22]);
                d1      <= fix(sh[21:18]);
                d0      <= fix(sh[17:14]);
                bin_reg <= sh[13:0];
                n       <= n - 4'd1;
            end
        end
    end

    assign ready     = (state == IDLE);
    assign done_tick = (state == DONE);
    assign bin       = bin_reg;
endmodule

// File: tb/tb_bcd2bin.sv
// tb_bcd2bin: directed vectors plus a latency/value model checked every cycle
module tb_bcd2bin;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  bcd3 = '0, bcd2 = '0, bcd1 = '0, bcd0 = '0;
    logic        ready, done_tick, err;
    logic [13:0] bin;

    int total = 0;
    int bad = 0;

    bcd2bin dut (
        .clk(clk), .reset(reset), .start(start),
        .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0),
        .ready(ready), .done_tick(done_tick), .err(err), .bin(bin)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // model: edge index e, busy window and expected result derived from digit arithmetic
    int e = 0;
    int busy_until = -1;
    int done_edge = -1;
    int last_done = -1;
    int m_bin = 0;
    bit m_err = 0;
    bit m_bad = 0;
    bit armed = 0;

    always @(posedge clk) begin
        int t;
        t = e;
        e++;
        if (reset) begin
            armed = 1;
            busy_until = -1;
            done_edge = -1;
            m_bin = 0;
            m_err = 0;
            m_bad = 0;
        end else if ((t - 1) > busy_until && start) begin
            m_bad = (bcd3 > 9) || (bcd2 > 9) || (bcd1 > 9) || (bcd0 > 9);
            m_err = m_bad;
            m_bin = m_bad ? 0 : 1000 * int'(bcd3) + 100 * int'(bcd2) + 10 * int'(bcd1) + int'(bcd0);
            done_edge = t + (m_bad ? 0 : 14);
            busy_until = done_edge;
        end
    end

    always @(negedge clk) begin
        int l;
        l = e - 1;
        if (armed) begin
            chk("ready", ready, l > busy_until);
            chk("done_tick", done_tick, l == done_edge);
            chk("err", err, m_err);
            if (m_bad || l >= done_edge) chk("bin", bin, m_bin);
            if (done_tick) last_done = l;
        end
    end

    // caller is at a negedge; returns at the negedge of the first ready cycle
    task automatic convert(input logic [3:0] a, b, c, d, input int want_bin, input bit want_err, input int want_lat);
        int k;
        {bcd3, bcd2, bcd1, bcd0} = {a, b, c, d};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (!done_tick && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (want_lat > 0) begin
            chk("latency", k, want_lat);
            chk("lit_bin", bin, want_bin);
            chk("lit_err", err, want_err);
        end
        @(negedge clk);
        if (want_lat > 0) chk("lit_ready", ready, 1);
    endtask

    initial begin
        int first;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_ready", ready, 1);
        chk("rst_bin", bin, 0);
        chk("rst_done", done_tick, 0);
        @(negedge clk);
        convert(9, 9, 9, 9, 9999, 0, 15);
        convert(0, 0, 0, 0, 0, 0, 15);
        convert(0, 1, 2, 8, 128, 0, 15);
        convert(4, 0, 9, 6, 4096, 0, 15);
        convert(1, 4'hA, 0, 0, 0, 1, 1);
        convert(5, 0, 0, 0, 5000, 0, 15);
        convert(0, 0, 0, 4'hF, 0, 1, 1);
        // start re-pulsed during op and in the done cycle, digits changed after capture
        {bcd3, bcd2, bcd1, bcd0} = {4'd9, 4'd9, 4'd9, 4'd9};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        {bcd3, bcd2, bcd1, bcd0} = {4'd1, 4'd1, 4'd1, 4'd1};
        for (int k = 1; k < 15; k++) begin
            start = (k == 3);
            @(negedge clk);
        end
        start = 1'b1;
        chk("repulse_done", done_tick, 1);
        chk("repulse_bin", bin, 9999);
        @(negedge clk);
        start = 1'b0;
        chk("repulse_ready", ready, 1);
        repeat (3) @(negedge clk);
        chk("repulse_idle", ready, 1);
        // reset in cycle 7 aborts the conversion
        {bcd3, bcd2, bcd1, bcd0} = {4'd9, 4'd9, 4'd9, 4'd9};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_ready", ready, 1);
        chk("abort_bin", bin, 0);
        chk("abort_err", err, 0);
        chk("abort_done", done_tick, 0);
        repeat (20) @(negedge clk);
        convert(0, 0, 4, 2, 42, 0, 15);
        // reset and start together: reset wins
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        chk("rst_start_ready", ready, 1);
        repeat (3) @(negedge clk);
        chk("rst_start_idle", ready, 1);
        // back-to-back: second done exactly 16 cycles after the first
        convert(1, 2, 3, 4, 1234, 0, 15);
        first = last_done;
        convert(8, 7, 6, 5, 8765, 0, 15);
        chk("b2b_spacing", last_done - first, 16);
        // sparse sweep of the valid range against the model
        for (int v = 0; v < 10000; v += 7) begin
            convert(4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10), 0, 0, 0);
        end
        convert(9, 9, 9, 8, 0, 0, 0);
        convert(4'hB, 9, 9, 9, 0, 1, 1);
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
